passcode_engine: RTL and testbench

PASSCODE_ENGINE -- requirements
Module: passcode_engine

---
 rtl/passcode_pkg.sv | 12 +
 rtl/passcode_engine_if.sv | 34 +++
 rtl/passcode_cmp_seq.sv | 55 +++++
 rtl/passcode_engine.sv | 141 ++++++++++++++
 tb/tb_passcode_engine.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/passcode_pkg.sv
// Shared FSM state type for the passcode engine; the encodings are what state_o reports.
package passcode_pkg;

  typedef enum logic [2:0] {
    ST_UNSET   = 3'd0,
    ST_READY   = 3'd1,
    ST_ENROLL  = 3'd2,
    ST_CHECK   = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_t;

endpackage

// File: rtl/passcode_engine_if.sv
// Keypad-side bus of the passcode engine.
// Handshake: digit_valid, enroll, submit and clear are one-cycle strobes with no
// ready signal; busy acts as the only backpressure, and any strobe presented while
// busy=1 is dropped by the engine. display_sel is a level input.
interface passcode_engine_if #(
  parameter int DIGIT_W = 4,
  parameter int MAX_LEN = 8
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic                       digit_valid;
  logic [DIGIT_W-1:0]         digit;
  logic                       enroll;
  logic                       submit;
  logic                       clear;
  logic                       display_sel;
  logic [MAX_LEN*DIGIT_W-1:0] disp_digits;
  logic [LEN_W-1:0]           entry_len;
  logic [2:0]                 state_o;
  logic                       correct;
  logic                       incorrect;
  logic                       locked;
  logic                       busy;

  modport master (
    output digit_valid, digit, enroll, submit, clear, display_sel,
    input  disp_digits, entry_len, state_o, correct, incorrect, locked, busy
  );

  modport slave (
    input  digit_valid, digit, enroll, submit, clear, display_sel,
    output disp_digits, entry_len, state_o, correct, incorrect, locked, busy
  );
endinterface

// File: rtl/passcode_cmp_seq.sv
// Serial slot comparator: after start, checks one slot per cycle across all
// MAX_LEN slots (no early exit, so latency never depends on the data) and
// raises done together with the final match verdict on the last slot.
module passcode_cmp_seq #(
  parameter int DIGIT_W = 4,
  parameter int MAX_LEN = 8,
  localparam int LEN_W  = $clog2(MAX_LEN + 1),
  localparam int IDX_W  = $clog2(MAX_LEN)
) (
  input  logic                       clk,
  input  logic                       input_reset,
  input  logic                       start,
  input  logic                       len_eq,
  input  logic [LEN_W-1:0]           cmp_len,
  input  logic [MAX_LEN*DIGIT_W-1:0] buf_a,
  input  logic [MAX_LEN*DIGIT_W-1:0] buf_b,
  output logic                       done,
  output logic                       match
);
  logic             running;
  logic [IDX_W-1:0] idx;
  logic             acc;
  logic             slot_ok;

  // Slots beyond the stored length are don't-care; used slots must be equal.
  always_comb begin
    slot_ok = 1'b1;
    if (int'(idx) < int'(cmp_len))
      slot_ok = (buf_a[int'(idx)*DIGIT_W +: DIGIT_W] == buf_b[int'(idx)*DIGIT_W +: DIGIT_W]);
  end

  assign done  = running && (idx == IDX_W'(MAX_LEN - 1));
  assign match = acc && slot_ok;

  // Walk the slot index and fold each slot result into the running verdict.
  always_ff @(posedge clk or negedge input_reset) begin
    if (!input_reset) begin
      running <= 1'b0;
      idx     <= '0;
      acc     <= 1'b0;
    end else if (start) begin
      running <= 1'b1;
      idx     <= '0;
      acc     <= len_eq;
    end else if (running) begin
      acc <= acc && slot_ok;
      if (done) begin
        running <= 1'b0;
        idx     <= '0;
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end
endmodule

// File: rtl/passcode_engine.sv
// Passcode engine: enrolls a stored code, collects entered digits, compares them
// with a fixed-latency serial compare, and locks out after repeated failures.
module passcode_engine
  import passcode_pkg::*;
#(
  parameter int DIGIT_W     = 4,
  parameter int MAX_LEN     = 8,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 1000
) (
  input  logic          clk,
  input  logic          input_reset,
  passcode_engine_if.slave bus
);
  localparam int LEN_W  = $clog2(MAX_LEN + 1);
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);
  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
  localparam int BUF_W  = MAX_LEN * DIGIT_W;

  state_t             state, state_n;
  logic [BUF_W-1:0]   stored_buf, stored_n, entry_buf, entry_n;
  logic [LEN_W-1:0]   stored_len, stored_len_n, entry_len, entry_len_n;
  logic [FAIL_W-1:0]  fail_cnt, fail_n;
  logic [LOCK_W-1:0]  lock_cnt, lock_n;
  logic               correct_r, correct_n, incorrect_r, incorrect_n;
  logic               ovf_r, ovf_n, prev_ok, prev_ok_n;
  logic               cmp_start, cmp_done, cmp_match, busy_w;

  assign busy_w = (state == ST_CHECK) || (state == ST_LOCKOUT);

  passcode_cmp_seq #(.DIGIT_W(DIGIT_W), .MAX_LEN(MAX_LEN)) u_cmp (
    .clk(clk), .input_reset(input_reset), .start(cmp_start),
    .len_eq(entry_len == stored_len), .cmp_len(stored_len),
    .buf_a(entry_buf), .buf_b(stored_buf), .done(cmp_done), .match(cmp_match)
  );

  // Next state and next datapath values; strobe priority is clear > submit > enroll > digit.
  always_comb begin
    state_n = state;  stored_n = stored_buf;  stored_len_n = stored_len;
    entry_n = entry_buf;  entry_len_n = entry_len;  fail_n = fail_cnt;
    lock_n = lock_cnt;  correct_n = correct_r;  incorrect_n = incorrect_r;
    ovf_n = 1'b0;  prev_ok_n = prev_ok;  cmp_start = 1'b0;
    if (!busy_w && (bus.digit_valid || bus.enroll)) begin
      correct_n   = 1'b0;
      incorrect_n = 1'b0;
    end
    case (state)
      ST_UNSET: begin
        if (bus.enroll && !bus.clear && !bus.submit) begin
          state_n = ST_ENROLL;  stored_n = '0;  stored_len_n = '0;  prev_ok_n = 1'b0;
        end
      end
      ST_ENROLL: begin
        if (bus.clear) begin
          stored_n = '0;  stored_len_n = '0;
        end else if (bus.submit) begin
          state_n = (stored_len != '0) ? ST_READY : ST_UNSET;
          entry_n = '0;  entry_len_n = '0;
        end else if (bus.enroll) begin
          state_n = ST_ENROLL;
        end else if (bus.digit_valid && (int'(stored_len) < MAX_LEN)) begin
          stored_n[int'(stored_len)*DIGIT_W +: DIGIT_W] = bus.digit;
          stored_len_n = stored_len + LEN_W'(1);
        end
      end
      ST_READY: begin
        if (bus.clear) begin
          entry_n = '0;  entry_len_n = '0;
        end else if (bus.submit) begin
          state_n = ST_CHECK;  cmp_start = 1'b1;
        end else if (bus.enroll) begin
          if (prev_ok) begin
            state_n = ST_ENROLL;  stored_n = '0;  stored_len_n = '0;
            entry_n = '0;  entry_len_n = '0;  prev_ok_n = 1'b0;
          end
        end else if (bus.digit_valid) begin
          if (int'(entry_len) < MAX_LEN) begin
            entry_n[int'(entry_len)*DIGIT_W +: DIGIT_W] = bus.digit;
            entry_len_n = entry_len + LEN_W'(1);
          end else begin
            ovf_n = 1'b1;
          end
        end
      end
      ST_CHECK: begin
        if (cmp_done) begin
          entry_n = '0;  entry_len_n = '0;
          if (cmp_match) begin
            correct_n = 1'b1;  incorrect_n = 1'b0;  fail_n = '0;
            prev_ok_n = 1'b1;  state_n = ST_READY;
          end else begin
            correct_n = 1'b0;  incorrect_n = 1'b1;  prev_ok_n = 1'b0;
            fail_n = fail_cnt + FAIL_W'(1);
            if (int'(fail_cnt) + 1 >= MAX_FAIL) begin
              state_n = ST_LOCKOUT;  lock_n = '0;
            end else begin
              state_n = ST_READY;
            end
          end
        end
      end
      ST_LOCKOUT: begin
        if (lock_cnt == LOCK_W'(LOCK_CYCLES - 1)) begin
          lock_n = '0;  fail_n = '0;  incorrect_n = 1'b0;  state_n = ST_READY;
        end else begin
          lock_n = lock_cnt + LOCK_W'(1);
        end
      end
      default: state_n = ST_UNSET;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge input_reset) begin
    if (!input_reset) state <= ST_UNSET;
    else              state <= state_n;
  end

  // Buffers, lengths, counters and result flags.
  always_ff @(posedge clk or negedge input_reset) begin
    if (!input_reset) begin
      stored_buf <= '0;  stored_len <= '0;  entry_buf <= '0;  entry_len <= '0;
      fail_cnt <= '0;  lock_cnt <= '0;  correct_r <= 1'b0;  incorrect_r <= 1'b0;
      ovf_r <= 1'b0;  prev_ok <= 1'b0;
    end else begin
      stored_buf <= stored_n;  stored_len <= stored_len_n;
      entry_buf <= entry_n;  entry_len <= entry_len_n;
      fail_cnt <= fail_n;  lock_cnt <= lock_n;
      correct_r <= correct_n;  incorrect_r <= incorrect_n;
      ovf_r <= ovf_n;  prev_ok <= prev_ok_n;
    end
  end

  assign bus.disp_digits = bus.display_sel ? entry_buf : stored_buf;
  assign bus.entry_len   = entry_len;
  assign bus.state_o     = state;
  assign bus.correct     = correct_r;
  assign bus.incorrect   = incorrect_r | ovf_r;
  assign bus.locked      = (state == ST_LOCKOUT);
  assign bus.busy        = busy_w;
endmodule

// File: tb/tb_passcode_engine.sv
// Directed bench for passcode_engine: enrollment, compare latency, mismatch and
// lockout, entry overflow, clear/submit priority and reset during a compare.
module tb_passcode_engine;
  localparam int DIGIT_W     = 4;
  localparam int MAX_LEN     = 8;
  localparam int MAX_FAIL    = 3;
  localparam int LOCK_CYCLES = 20;

  localparam logic [2:0] S_UNSET = 3'd0, S_READY = 3'd1, S_ENROLL = 3'd2,
                         S_CHECK = 3'd3, S_LOCK = 3'd4;

  logic clk;
  logic input_reset;
  int   n_vec;
  int   n_bad;

  passcode_engine_if #(.DIGIT_W(DIGIT_W), .MAX_LEN(MAX_LEN)) bus ();

  passcode_engine #(
    .DIGIT_W(DIGIT_W), .MAX_LEN(MAX_LEN), .MAX_FAIL(MAX_FAIL), .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .clk(clk), .input_reset(input_reset), .bus(bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks: present a strobe for one cycle, return at the negedge after it was taken
  task automatic strobe(input logic dv, input logic [3:0] d, input logic en,
                        input logic sb, input logic cl);
    @(negedge clk);
    bus.digit_valid = dv;  bus.digit = d;  bus.enroll = en;
    bus.submit = sb;  bus.clear = cl;
    @(negedge clk);
    bus.digit_valid = 1'b0;  bus.digit = '0;  bus.enroll = 1'b0;
    bus.submit = 1'b0;  bus.clear = 1'b0;
  endtask

  task automatic key(input logic [3:0] d);
    strobe(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_submit();
    strobe(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic do_enroll();
    strobe(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
  endtask

  // counts cycles spent in CHECK (bounded); flags any early result
  task automatic wait_check(output int n, output logic early);
    n = 0;
    early = 1'b0;
    while (bus.state_o == S_CHECK && n < 200) begin
      n++;
      if (bus.correct || bus.incorrect) early = 1'b1;
      @(negedge clk);
    end
  endtask

  int   n;
  logic early;

  initial begin
    n_vec = 0;  n_bad = 0;
    input_reset = 1'b0;
    bus.digit_valid = 1'b0;  bus.digit = '0;  bus.enroll = 1'b0;
    bus.submit = 1'b0;  bus.clear = 1'b0;  bus.display_sel = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", bus.state_o, S_UNSET);
    chk("rst_busy", bus.busy, 0);
    input_reset = 1'b1;

    // UNSET ignores submit and digits
    do_submit();
    chk("unset_submit", bus.state_o, S_UNSET);
    key(4'd7);
    bus.display_sel = 1'b1;
    #1;
    chk("unset_digit_len", bus.entry_len, 0);
    chk("unset_digit_disp", bus.disp_digits, 0);

    // enroll 1-2-3-4
    do_enroll();
    chk("enroll_state", bus.state_o, S_ENROLL);
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    bus.display_sel = 1'b0;
    #1;
    chk("stored_disp", bus.disp_digits, 64'h4321);
    do_submit();
    chk("enroll_done", bus.state_o, S_READY);

    // correct entry: fixed latency
    bus.display_sel = 1'b1;
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    chk("entry_len4", bus.entry_len, 4);
    chk("entry_disp", bus.disp_digits, 64'h4321);
    do_submit();
    wait_check(n, early);
    chk("busy_cycles", n, MAX_LEN);
    chk("no_early_result", early, 0);
    chk("correct", bus.correct, 1);
    chk("correct_incorrect", bus.incorrect, 0);
    chk("correct_len_clr", bus.entry_len, 0);
    chk("correct_state", bus.state_o, S_READY);

    // digit clears correct; clear empties the entry
    key(4'd5);
    chk("digit_clr_correct", bus.correct, 0);
    chk("digit_len1", bus.entry_len, 1);
    strobe(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    chk("clear_len", bus.entry_len, 0);

    // length mismatch 1-2-3
    key(4'd1); key(4'd2); key(4'd3);
    do_submit();
    wait_check(n, early);
    chk("short_cycles", n, MAX_LEN);
    chk("short_incorrect", bus.incorrect, 1);
    chk("short_fail_cnt", dut.fail_cnt, 1);
    chk("short_state", bus.state_o, S_READY);

    // two more failures -> lockout
    key(4'd1); key(4'd2); key(4'd3); key(4'd5);
    do_submit();
    wait_check(n, early);
    chk("fail2_cnt", dut.fail_cnt, 2);
    key(4'd9);
    do_submit();
    wait_check(n, early);
    chk("lock_state", bus.state_o, S_LOCK);
    chk("lock_busy", bus.busy, 1);
    n = 0;
    while (bus.locked && n < 200) begin
      n++;
      bus.digit_valid = (n == 3);
      bus.digit = 4'd7;
      bus.submit = (n == 6);
      @(negedge clk);
    end
    bus.digit_valid = 1'b0;  bus.submit = 1'b0;
    chk("lock_cycles", n, LOCK_CYCLES);
    chk("unlock_state", bus.state_o, S_READY);
    chk("unlock_incorrect", bus.incorrect, 0);
    chk("unlock_fail_cnt", dut.fail_cnt, 0);
    chk("lock_digit_ignored", bus.entry_len, 0);

    // re-enroll only allowed after a correct result
    do_enroll();
    chk("enroll_blocked", bus.state_o, S_READY);
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    do_submit();
    wait_check(n, early);
    chk("correct2", bus.correct, 1);
    do_enroll();
    chk("reenroll_state", bus.state_o, S_ENROLL);
    chk("reenroll_clr_correct", bus.correct, 0);
    key(4'd5); key(4'd6);
    do_submit();
    chk("reenroll_done", bus.state_o, S_READY);

    // overflow: ninth digit dropped with a one-cycle incorrect pulse
    for (int i = 1; i <= MAX_LEN; i++) key(4'(i));
    chk("full_len", bus.entry_len, MAX_LEN);
    chk("full_no_incorrect", bus.incorrect, 0);
    key(4'd9);
    chk("ovf_pulse", bus.incorrect, 1);
    chk("ovf_len", bus.entry_len, MAX_LEN);
    chk("ovf_disp", bus.disp_digits, 64'h87654321);
    @(negedge clk);
    chk("ovf_pulse_end", bus.incorrect, 0);

    // clear beats submit
    strobe(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    key(4'd5); key(4'd6);
    chk("two_len", bus.entry_len, 2);
    strobe(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
    chk("clrsub_len", bus.entry_len, 0);
    chk("clrsub_disp", bus.disp_digits, 0);
    chk("clrsub_state", bus.state_o, S_READY);
    @(negedge clk);
    chk("clrsub_no_check", bus.state_o, S_READY);

    // reset in the middle of a compare
    key(4'd5); key(4'd6);
    do_submit();
    repeat (2) @(negedge clk);
    chk("mid_check", bus.state_o, S_CHECK);
    input_reset = 1'b0;
    #1;
    chk("async_rst_state", bus.state_o, S_UNSET);
    chk("async_rst_busy", bus.busy, 0);
    @(negedge clk);
    input_reset = 1'b1;
    chk("post_rst_state", bus.state_o, S_UNSET);
    chk("post_rst_outs", {bus.correct, bus.incorrect, bus.locked, bus.busy}, 4'b0000);
    chk("post_rst_entry", bus.disp_digits, 0);
    bus.display_sel = 1'b0;
    #1;
    chk("post_rst_stored", bus.disp_digits, 0);
    do_submit();
    chk("post_rst_submit", bus.state_o, S_UNSET);
    chk("post_rst_busy2", bus.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
